// File: rtl/pc_next_unit.sv
// Next-PC selector and PC register for the fetch stage.
// Picks PC+INC or a redirect target each cycle. A redirect seen while fetch is
// stalled is held in a one-entry pending register and applied on stall release.
module pc_next_unit #(
   parameter int unsigned          DATA_W   = 32,
   parameter int unsigned          NUM_SRC  = 4,
   parameter logic [DATA_W-1:0]    RESET_PC = DATA_W'(32'h0000_3000),
   parameter int unsigned          INC      = 4,
   localparam int unsigned         SEL_W    = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      stall_i,
   input  logic                      redir_valid_i,
   input  logic [SEL_W-1:0]          redir_sel_i,
   input  logic [NUM_SRC*DATA_W-1:0] src_bus_i,
   output logic [DATA_W-1:0]         pc_o,
   output logic [DATA_W-1:0]         pc_plus_o,
   output logic                      pend_o,
   output logic                      sel_err_o,
   output logic                      align_err_o
);

   localparam logic StIdle = 1'b0;
   localparam logic StPend = 1'b1;

   logic              state_q, state_d;
   logic [DATA_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] pend_q, pend_d;
   logic              sel_err_q, sel_err_d;
   logic              align_err_q, align_err_d;

   logic [DATA_W-1:0] seq_pc;
   logic [DATA_W-1:0] target;
   logic              sel_bad;

   // Slice 0 stands for the sequential source and carries no data.
   logic unused_slice0;
   assign unused_slice0 = ^src_bus_i[DATA_W-1:0];

   // Resolve the candidate next PC and flag illegal or misaligned redirects.
   always_comb begin
      seq_pc  = pc_q + DATA_W'(INC);
      target  = seq_pc;
      sel_bad = 1'b0;
      if (redir_valid_i && (redir_sel_i != '0)) begin
         if (32'(redir_sel_i) >= NUM_SRC) begin
            // Only reachable when NUM_SRC is not a power of two.
            target  = RESET_PC;
            sel_bad = 1'b1;
         end else begin
            for (int unsigned k = 1; k < NUM_SRC; k++) begin
               if (redir_sel_i == SEL_W'(k)) begin
                  target = src_bus_i[k*DATA_W +: DATA_W];
               end
            end
         end
      end
      // Every valid redirect is accepted (into the PC or the pending slot).
      sel_err_d   = sel_bad;
      align_err_d = redir_valid_i && (target[1:0] != 2'b00);
   end

   // Stall/pending FSM: decides what lands in the PC and the pending slot.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      pend_d  = pend_q;
      case (state_q)
         StIdle: begin
            if (!stall_i) begin
               pc_d = target;
            end else if (redir_valid_i) begin
               pend_d  = target;
               state_d = StPend;
            end
         end
         StPend: begin
            if (stall_i) begin
               // Newest redirect wins while still stalled.
               if (redir_valid_i) begin
                  pend_d = target;
               end
            end else begin
               pc_d    = redir_valid_i ? target : pend_q;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         pc_q        <= RESET_PC;
         pend_q      <= '0;
         sel_err_q   <= 1'b0;
         align_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         pend_q      <= pend_d;
         sel_err_q   <= sel_err_d;
         align_err_q <= align_err_d;
      end
   end

   assign pc_o        = pc_q;
   assign pc_plus_o   = pc_q + DATA_W'(INC);
   assign pend_o      = (state_q == StPend);
   assign sel_err_o   = sel_err_q;
   assign align_err_o = align_err_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed self-checking bench for pc_next_unit: one instance with four
// sources (power of two) and one with three (illegal select reachable).
module tb_pc_next_unit;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // Instance A: NUM_SRC = 4
   logic         stall_a, valid_a;
   logic [1:0]   sel_a;
   logic [127:0] bus_a;
   logic [31:0]  pc_a, plus_a;
   logic         pend_a, serr_a, aerr_a;

   // Instance B: NUM_SRC = 3
   logic         stall_b, valid_b;
   logic [1:0]   sel_b;
   logic [95:0]  bus_b;
   logic [31:0]  pc_b, plus_b;
   logic         pend_b, serr_b, aerr_b;

   int unsigned checks = 0;
   int unsigned errors = 0;

   pc_next_unit #(.NUM_SRC(4)) u_dut_a (
      .clk          (clk),
      .reset        (reset),
      .stall_i      (stall_a),
      .redir_valid_i(valid_a),
      .redir_sel_i  (sel_a),
      .src_bus_i    (bus_a),
      .pc_o         (pc_a),
      .pc_plus_o    (plus_a),
      .pend_o       (pend_a),
      .sel_err_o    (serr_a),
      .align_err_o  (aerr_a)
   );

   pc_next_unit #(.NUM_SRC(3)) u_dut_b (
      .clk          (clk),
      .reset        (reset),
      .stall_i      (stall_b),
      .redir_valid_i(valid_b),
      .redir_sel_i  (sel_b),
      .src_bus_i    (bus_b),
      .pc_o         (pc_b),
      .pc_plus_o    (plus_b),
      .pend_o       (pend_b),
      .sel_err_o    (serr_b),
      .align_err_o  (aerr_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a redirect on instance A with the given slice target.
   task automatic redir_a(input logic [1:0] s, input logic [31:0] tgt);
      valid_a = 1'b1;
      sel_a   = s;
      bus_a   = '0;
      bus_a[s*32 +: 32] = tgt;
   endtask

   initial begin
      reset   = 1'b1;
      stall_a = 1'b0; valid_a = 1'b0; sel_a = '0; bus_a = '0;
      stall_b = 1'b0; valid_b = 1'b0; sel_b = '0; bus_b = '0;

      // Reset state
      tick();
      check("rst_pc",    pc_a,   32'h3000);
      check("rst_plus",  plus_a, 32'h3004);
      check("rst_pend",  {31'b0, pend_a}, 32'd0);
      check("rst_serr",  {31'b0, serr_a}, 32'd0);
      check("rst_aerr",  {31'b0, aerr_a}, 32'd0);
      reset = 1'b0;

      // Free run
      tick(); check("run1", pc_a, 32'h3004);
      tick(); check("run2", pc_a, 32'h3008);
      check("run_pend", {31'b0, pend_a}, 32'd0);

      // Redirect with sel 0 behaves as sequential
      redir_a(2'd0, 32'h0);
      tick(); check("sel0_seq", pc_a, 32'h300c);
      check("sel0_aerr", {31'b0, aerr_a}, 32'd0);

      // Redirect, no stall
      redir_a(2'd2, 32'h4000);
      tick(); check("redir", pc_a, 32'h4000);
      valid_a = 1'b0;
      tick(); check("redir_seq", pc_a, 32'h4004);

      // Stall with no redirect holds
      stall_a = 1'b1;
      tick(); check("stall_hold", pc_a, 32'h4004);
      check("stall_nopend", {31'b0, pend_a}, 32'd0);

      // Buffered redirect, newest wins
      redir_a(2'd1, 32'h5000);
      tick(); check("buf_hold", pc_a, 32'h4004);
      check("buf_pend", {31'b0, pend_a}, 32'd1);
      redir_a(2'd3, 32'h6000);
      tick(); check("buf2_pend", {31'b0, pend_a}, 32'd1);
      check("buf2_hold", pc_a, 32'h4004);
      valid_a = 1'b0;
      tick(); check("pend_hold", pc_a, 32'h4004);
      stall_a = 1'b0;
      tick(); check("release_pc", pc_a, 32'h6000);
      check("release_pend", {31'b0, pend_a}, 32'd0);
      tick(); check("release_seq", pc_a, 32'h6004);

      // Release together with a new redirect
      stall_a = 1'b1;
      redir_a(2'd1, 32'h5000);
      tick(); check("sim_pend", {31'b0, pend_a}, 32'd1);
      stall_a = 1'b0;
      redir_a(2'd2, 32'h7000);
      tick(); check("sim_pc", pc_a, 32'h7000);
      check("sim_pend0", {31'b0, pend_a}, 32'd0);
      valid_a = 1'b0;
      tick(); check("sim_seq", pc_a, 32'h7004);

      // Wrap at the top of the address space
      redir_a(2'd1, 32'hffff_fffc);
      tick(); check("wrap_pre", pc_a, 32'hffff_fffc);
      check("wrap_plus", plus_a, 32'h0);
      valid_a = 1'b0;
      tick(); check("wrap", pc_a, 32'h0);

      // Reset while a redirect is pending
      stall_a = 1'b1;
      redir_a(2'd1, 32'h9000);
      tick(); check("rp_pend", {31'b0, pend_a}, 32'd1);
      valid_a = 1'b0;
      reset   = 1'b1;
      tick(); check("rp_pc", pc_a, 32'h3000);
      check("rp_pend0", {31'b0, pend_a}, 32'd0);
      check("rp_b_pc", pc_b, 32'h3000);
      reset   = 1'b0;
      stall_a = 1'b0;
      tick(); check("rp_seq", pc_a, 32'h3004);
      check("b_seq", pc_b, 32'h3004);

      // Illegal select on NUM_SRC=3
      valid_b = 1'b1; sel_b = 2'd3;
      tick(); check("serr_pc", pc_b, 32'h3000);
      check("serr_pulse", {31'b0, serr_b}, 32'd1);
      valid_b = 1'b0;
      tick(); check("serr_clear", {31'b0, serr_b}, 32'd0);
      check("serr_seq", pc_b, 32'h3004);

      // Misaligned target is loaded and flagged once
      valid_b = 1'b1; sel_b = 2'd1; bus_b = '0; bus_b[32 +: 32] = 32'h8002;
      tick(); check("align_pc", pc_b, 32'h8002);
      check("align_pulse", {31'b0, aerr_b}, 32'd1);
      check("align_noserr", {31'b0, serr_b}, 32'd0);
      valid_b = 1'b0;
      tick(); check("align_clear", {31'b0, aerr_b}, 32'd0);
      check("align_seq", pc_b, 32'h8006);

      // Illegal select accepted into the pending slot
      stall_b = 1'b1; valid_b = 1'b1; sel_b = 2'd3;
      tick(); check("pserr_pulse", {31'b0, serr_b}, 32'd1);
      check("pserr_pend", {31'b0, pend_b}, 32'd1);
      check("pserr_hold", pc_b, 32'h8006);
      valid_b = 1'b0;
      tick(); check("pserr_clear", {31'b0, serr_b}, 32'd0);
      stall_b = 1'b0;
      tick(); check("pserr_pc", pc_b, 32'h3000);
      check("pserr_pend0", {31'b0, pend_b}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_next_unit.md
# pc_next_unit

Parametrised next-PC selector with integrated PC register for the fetch stage of the MIPS pipeline. Each cycle it picks the sequential address (PC+INC) or one of several redirect sources (branch, jump, jump-register, exception vector). It registers the result as the current PC. A redirect that arrives while fetch is stalled is buffered and applied when the stall releases, so it is never lost.

## Interface

Parameters:
- DATA_W, 32, address width.
- NUM_SRC, 4, number of select sources including the sequential source 0 (range 2–16).
- RESET_PC, 32'h0000_3000, PC value after reset; also the value loaded on an illegal select.
- INC, 4, sequential increment.
- SEL_W, derived as clog2(NUM_SRC) (minimum 1), not overridden.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- stall_i  in  1  hold the PC; fetch is frozen.
- redir_valid_i  in  1  a redirect is requested this cycle.
- redir_sel_i  in  SEL_W  source index for the redirect.
- src_bus_i  in  NUM_SRC*DATA_W  packed targets; slice k is bits [k*DATA_W +: DATA_W]; slice 0 is ignored.
- pc_o  out  DATA_W  current PC (registered).
- pc_plus_o  out  DATA_W  pc_o + INC (combinational from pc_o).
- pend_o  out  1  a buffered redirect is waiting.
- sel_err_o  out  1  one-cycle pulse when an illegal select was accepted.
- align_err_o  out  1  one-cycle pulse when a misaligned target was loaded (target[1:0] != 0).

## Operation

- Target resolution:
  - redir_sel_i == 0, or redir_valid_i == 0 → sequential, next = pc_o + INC.
  - 1 ≤ sel < NUM_SRC → slice sel of src_bus_i.
  - sel ≥ NUM_SRC (only possible when NUM_SRC is not a power of two) → RESET_PC, and sel_err_o pulses.
- Redirect with sel 0 is legal and equals sequential.
- Two-state FSM, IDLE and PEND; the pending register holds one target.
- IDLE:
  - stall_i=0: pc_o ← resolved target.
  - stall_i=1, redir_valid_i=0: pc_o holds.
  - stall_i=1, redir_valid_i=1: pending ← resolved target, go to PEND; pc_o holds.
- PEND:
  - stall_i=1, redir_valid_i=0: hold everything.
  - stall_i=1, redir_valid_i=1: pending overwritten by the new target (newest wins); stay in PEND.
  - stall_i=0, redir_valid_i=0: pc_o ← pending, go to IDLE.
  - stall_i=0, redir_valid_i=1: pc_o ← new resolved target (newest wins), pending discarded, go to IDLE.
- pend_o = (state == PEND).
- Error pulses:
  - Error checks happen when a target is resolved with redir_valid_i=1, whether it goes to the PC or to the pending register.
  - sel_err_o and align_err_o are registered and assert in the cycle after acceptance.
  - align_err_o compares the resolved target only; the misaligned value is still used.
- Arithmetic is unsigned modulo 2^DATA_W; PC+INC wraps silently.

## Timing

- Reset (synchronous, dominant over all inputs): pc_o=RESET_PC, pc_plus_o=RESET_PC+INC, pend_o=0, sel_err_o=0, align_err_o=0, state IDLE, pending register cleared to 0.
- Reset asserted in PEND discards the buffered redirect.
- Latency:
  - A redirect with stall low is visible on pc_o one cycle after the edge at which it is sampled.
  - A buffered redirect is visible one cycle after the first edge with stall_i=0.
- Inputs are sampled only at the rising edge of clk; there is no combinational path from inputs to pc_o.

## Test plan

- Reset then free-run, NUM_SRC=4, no stall: pc_o = 0x3000, 0x3004, 0x3008 on consecutive cycles; pend_o=0 throughout.
- Redirect, no stall: redir_valid_i=1, sel=2, slice2=0x0000_4000 → pc_o=0x4000 next cycle; the following cycle pc_o=0x4004.
- Buffered redirect:
  - With stall_i=1, present sel=1 target 0x5000 → pc_o holds and pend_o=1.
  - Then present sel=3 target 0x6000 while stall is still high → pend_o remains 1.
  - Release stall → pc_o=0x6000 and pend_o=0.
- Simultaneous release and redirect: pending=0x5000, stall drops in the same cycle as redir sel=2 target 0x7000 → pc_o=0x7000, pend_o=0.
- Errors, NUM_SRC=3:
  - sel=3 → pc_o=0x3000 and sel_err_o pulses for exactly one cycle.
  - sel=1 target 0x8002 → pc_o=0x8002 and align_err_o pulses once.
- Wrap and reset mid-operation:
  - pc_o=0xFFFF_FFFC with no redirect → pc_o=0x0000_0000 next cycle.
  - reset asserted while pend_o=1 → pc_o=0x3000 and pend_o=0 next cycle; the buffered target is never loaded.
